// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int   MEM_AW = 10;
   localparam int   MEM_DW = 32;
   localparam logic OWN_I  = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Each byte enable covers eight bit write enables of the memory macro.
   function automatic logic [MEM_DW-1:0] be2bwen(input logic [MEM_DW/8-1:0] be);
      logic [MEM_DW-1:0] bw;
      bw = '0;
      for (int k = 0; k < MEM_DW/8; k++) begin
         bw[8*k +: 8] = {8{be[k]}};
      end
      return bw;
   endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way arbiter: round-robin or fixed D priority when both requesters collide.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rr_en,
   input  logic req_i,
   input  logic req_d,
   output logic gnt_i,
   output logic gnt_d
);

   logic last_q, last_d;
   logic contended;

   assign contended = req_i & req_d;

   always_comb begin
      gnt_i  = 1'b0;
      gnt_d  = 1'b0;
      last_d = last_q;
      if (contended) begin
         // Round-robin hands the slot to whoever lost the previous collision.
         if (!rr_en || last_q == OWN_I) begin
            gnt_d = 1'b1;
         end else begin
            gnt_i = 1'b1;
         end
         last_d = gnt_d ? OWN_D : OWN_I;
      end else begin
         gnt_i = req_i;
         gnt_d = req_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_I;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 1024x32 memory between instruction fetch and load/store,
// one access per cycle with the response returned on the following cycle.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          RR_EN     = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_REQ,
   input  logic [31:0]       I_ADDR,
   output logic              I_GNT,
   output logic              I_RVALID,
   output logic [31:0]       I_RDATA,
   output logic              I_ERR,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [3:0]        D_BE,
   input  logic [31:0]       D_ADDR,
   input  logic [31:0]       D_WDATA,
   output logic              D_GNT,
   output logic              D_RVALID,
   output logic [31:0]       D_RDATA,
   output logic              D_ERR,
   output logic              MEM_CEN,
   output logic              MEM_WEN,
   output logic [MEM_DW-1:0] MEM_BWEN,
   output logic [MEM_AW-1:0] MEM_A,
   output logic [MEM_DW-1:0] MEM_D,
   input  logic [MEM_DW-1:0] MEM_Q
);

   localparam logic RR_EN_B = (RR_EN != 0);

   logic        gnt_i, gnt_d, any_gnt;
   logic [31:0] addr;
   logic        addr_err, is_store;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_owner_q, rsp_owner_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_is_load_q, rsp_is_load_d;

   rr_arb2 u_arb (
      .clk   (CLK),
      .rst   (RST),
      .rr_en (RR_EN_B),
      .req_i (I_REQ & ~RST),
      .req_d (D_REQ & ~RST),
      .gnt_i (gnt_i),
      .gnt_d (gnt_d)
   );

   assign I_GNT    = gnt_i;
   assign D_GNT    = gnt_d;
   assign any_gnt  = gnt_i | gnt_d;
   assign addr     = gnt_d ? D_ADDR : I_ADDR;
   assign is_store = gnt_d & D_WE;
   assign addr_err = (addr[1:0] != 2'b00) || (addr[31:12] != BASE_ADDR[31:12]);

   always_comb begin
      MEM_CEN  = 1'b0;
      MEM_WEN  = 1'b1;
      MEM_BWEN = '0;
      MEM_A    = '0;
      MEM_D    = '0;
      // Faulting requests are still granted but never reach the memory.
      if (any_gnt && !addr_err) begin
         MEM_CEN  = 1'b1;
         MEM_WEN  = ~is_store;
         MEM_BWEN = is_store ? be2bwen(D_BE) : '0;
         MEM_A    = addr[11:2];
         MEM_D    = D_WDATA;
      end
   end

   assign rsp_valid_d   = any_gnt;
   assign rsp_owner_d   = gnt_d ? OWN_D : OWN_I;
   assign rsp_err_d     = addr_err;
   assign rsp_is_load_d = ~is_store;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
      end
      rsp_owner_q   <= rsp_owner_d;
      rsp_err_q     <= rsp_err_d;
      rsp_is_load_q <= rsp_is_load_d;
   end

   // Response stage: MEM_Q is only meaningful to the owner of a good read.
   assign I_RVALID = rsp_valid_q & ~RST & (rsp_owner_q == OWN_I);
   assign D_RVALID = rsp_valid_q & ~RST & (rsp_owner_q == OWN_D);
   assign I_ERR    = I_RVALID & rsp_err_q;
   assign D_ERR    = D_RVALID & rsp_err_q;
   assign I_RDATA  = (I_RVALID && !rsp_err_q && rsp_is_load_q) ? MEM_Q : '0;
   assign D_RDATA  = (D_RVALID && !rsp_err_q && rsp_is_load_q) ? MEM_Q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory model.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        I_REQ, D_REQ, D_WE;
   logic [31:0] I_ADDR, D_ADDR, D_WDATA;
   logic [3:0]  D_BE;
   logic        I_GNT, I_RVALID, I_ERR, D_GNT, D_RVALID, D_ERR;
   logic [31:0] I_RDATA, D_RDATA;
   logic        MEM_CEN, MEM_WEN;
   logic [31:0] MEM_BWEN, MEM_D, MEM_Q;
   logic [9:0]  MEM_A;

   logic        f_I_GNT, f_I_RVALID, f_I_ERR, f_D_GNT, f_D_RVALID, f_D_ERR;
   logic [31:0] f_I_RDATA, f_D_RDATA, f_MEM_BWEN, f_MEM_D;
   logic        f_MEM_CEN, f_MEM_WEN;
   logic [9:0]  f_MEM_A;

   logic [31:0] mem [0:1023];
   logic        preload;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.BASE_ADDR(32'h0000_0000), .RR_EN(1)) u_dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID),
      .I_RDATA(I_RDATA), .I_ERR(I_ERR),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
      .MEM_CEN(MEM_CEN), .MEM_WEN(MEM_WEN), .MEM_BWEN(MEM_BWEN), .MEM_A(MEM_A),
      .MEM_D(MEM_D), .MEM_Q(MEM_Q)
   );

   mem_arbiter #(.BASE_ADDR(32'h0000_0000), .RR_EN(0)) u_fp (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(f_I_GNT), .I_RVALID(f_I_RVALID),
      .I_RDATA(f_I_RDATA), .I_ERR(f_I_ERR),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(f_D_GNT), .D_RVALID(f_D_RVALID), .D_RDATA(f_D_RDATA), .D_ERR(f_D_ERR),
      .MEM_CEN(f_MEM_CEN), .MEM_WEN(f_MEM_WEN), .MEM_BWEN(f_MEM_BWEN), .MEM_A(f_MEM_A),
      .MEM_D(f_MEM_D), .MEM_Q(MEM_Q)
   );

   always @(posedge CLK) begin
      if (preload) begin
         mem[0] <= 32'h0101_0101;
         mem[1] <= 32'h0202_0202;
         mem[2] <= 32'h0303_0303;
         mem[4] <= 32'hDEAD_BEEF;
         mem[8] <= 32'h1122_3344;
      end else if (MEM_CEN) begin
         if (!MEM_WEN) mem[MEM_A] <= (mem[MEM_A] & ~MEM_BWEN) | (MEM_D & MEM_BWEN);
         else          MEM_Q <= mem[MEM_A];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic clr_req();
      I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'h0;
   endtask

   initial begin
      logic [3:0] rr_exp;
      RST = 1'b1; preload = 1'b1; clr_req();
      I_ADDR = 32'h10; D_ADDR = 32'h0; D_WDATA = 32'h55AA_55AA;
      I_REQ = 1'b1;

      // Reset holds off grants and the memory port even with a request pending.
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_i_gnt", I_GNT, 0);
      chk("rst_mem_cen", MEM_CEN, 0);
      chk("rst_i_rvalid", I_RVALID, 0);

      @(negedge CLK); RST = 1'b0; preload = 1'b0; clr_req(); #1;
      chk("idle_cen", MEM_CEN, 0);
      chk("idle_wen", MEM_WEN, 1);
      chk("idle_bwen", MEM_BWEN, 0);
      chk("idle_a", MEM_A, 0);
      chk("idle_d", MEM_D, 0);

      // Single fetch.
      @(negedge CLK); I_REQ = 1'b1; I_ADDR = 32'h10; #1;
      chk("f1_i_gnt", I_GNT, 1);
      chk("f1_d_gnt", D_GNT, 0);
      chk("f1_cen", MEM_CEN, 1);
      chk("f1_a", MEM_A, 4);
      chk("f1_wen", MEM_WEN, 1);
      chk("f1_bwen", MEM_BWEN, 0);
      @(negedge CLK); clr_req(); #1;
      chk("f1_rvalid", I_RVALID, 1);
      chk("f1_rdata", I_RDATA, 32'hDEAD_BEEF);
      chk("f1_err", I_ERR, 0);
      chk("f1_d_rvalid", D_RVALID, 0);

      // Partial store, then read back the merged word.
      @(negedge CLK); D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'b0101;
      D_ADDR = 32'h20; D_WDATA = 32'hAABB_CCDD; #1;
      chk("st_gnt", D_GNT, 1);
      chk("st_wen", MEM_WEN, 0);
      chk("st_bwen", MEM_BWEN, 32'h00FF_00FF);
      chk("st_a", MEM_A, 8);
      chk("st_d", MEM_D, 32'hAABB_CCDD);
      @(negedge CLK); D_WE = 1'b0; D_BE = 4'h0; #1;
      chk("st_rvalid", D_RVALID, 1);
      chk("st_err", D_ERR, 0);
      chk("st_rdata", D_RDATA, 0);
      @(negedge CLK); clr_req(); #1;
      chk("ld_rvalid", D_RVALID, 1);
      chk("ld_rdata", D_RDATA, 32'h11BB_33DD);

      // Contention: round-robin alternates starting with D; fixed priority keeps D.
      rr_exp = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK); I_REQ = 1'b1; I_ADDR = 32'h0; D_REQ = 1'b1; D_ADDR = 32'h4; #1;
         chk($sformatf("rr%0d_d_gnt", k), D_GNT, rr_exp[k]);
         chk($sformatf("rr%0d_i_gnt", k), I_GNT, !rr_exp[k]);
         chk($sformatf("fp%0d_d_gnt", k), f_D_GNT, 1);
         chk($sformatf("fp%0d_i_gnt", k), f_I_GNT, 0);
      end

      // Misaligned and out-of-window accesses.
      @(negedge CLK); clr_req(); D_REQ = 1'b1; D_ADDR = 32'h1002; #1;
      chk("mis_gnt", D_GNT, 1);
      chk("mis_cen", MEM_CEN, 0);
      @(negedge CLK); D_ADDR = 32'h2000; #1;
      chk("mis_rvalid", D_RVALID, 1);
      chk("mis_err", D_ERR, 1);
      chk("mis_rdata", D_RDATA, 0);
      chk("oow_gnt", D_GNT, 1);
      chk("oow_cen", MEM_CEN, 0);
      @(negedge CLK); clr_req(); #1;
      chk("oow_rvalid", D_RVALID, 1);
      chk("oow_err", D_ERR, 1);
      chk("oow_rdata", D_RDATA, 0);

      // Back-to-back fetches.
      @(negedge CLK); I_REQ = 1'b1; I_ADDR = 32'h0; #1;
      chk("b2b0_gnt", I_GNT, 1);
      @(negedge CLK); I_ADDR = 32'h4; #1;
      chk("b2b0_rvalid", I_RVALID, 1);
      chk("b2b0_rdata", I_RDATA, 32'h0101_0101);
      @(negedge CLK); I_ADDR = 32'h8; #1;
      chk("b2b1_rvalid", I_RVALID, 1);
      chk("b2b1_rdata", I_RDATA, 32'h0202_0202);
      @(negedge CLK); clr_req(); #1;
      chk("b2b2_rvalid", I_RVALID, 1);
      chk("b2b2_rdata", I_RDATA, 32'h0303_0303);

      // Leave D as last contention winner, then reset over an in-flight load.
      @(negedge CLK); I_REQ = 1'b1; I_ADDR = 32'h0; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h4; #1;
      chk("pre_d_gnt", D_GNT, 1);
      @(negedge CLK); I_REQ = 1'b0; #1;
      chk("rl_d_gnt", D_GNT, 1);
      @(negedge CLK); D_REQ = 1'b0; I_REQ = 1'b1; RST = 1'b1; #1;
      chk("rl_d_rvalid_rst", D_RVALID, 0);
      chk("rl_i_gnt_rst", I_GNT, 0);
      chk("rl_cen_rst", MEM_CEN, 0);
      @(negedge CLK); RST = 1'b0; clr_req(); #1;
      chk("rl_d_rvalid_after", D_RVALID, 0);
      chk("rl_cen_after", MEM_CEN, 0);
      @(negedge CLK); I_REQ = 1'b1; I_ADDR = 32'h10; #1;
      chk("post_i_gnt", I_GNT, 1);
      @(negedge CLK); D_REQ = 1'b1; D_ADDR = 32'h4; #1;
      chk("post_i_rvalid", I_RVALID, 1);
      chk("post_i_rdata", I_RDATA, 32'hDEAD_BEEF);
      chk("post_first_cont_d", D_GNT, 1);
      chk("post_first_cont_i", I_GNT, 0);
      @(negedge CLK); clr_req();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
